// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - command/width enums, read tag and byte-lane helpers for mem_port_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    W8  = 2'b01,
    W16 = 2'b10,
    W32 = 2'b11
  } width_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] ch;
    logic [1:0] off;
    width_e     width;
  } rd_tag_t;

  // Width code 00 is treated as a full word access.
  function automatic width_e norm_width(input logic [1:0] w);
    return (w == 2'b00) ? W32 : width_e'(w);
  endfunction

  function automatic logic [1:0] lane_off(input width_e w, input logic [1:0] a);
    case (w)
      W8:      return a;
      W16:     return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input width_e w, input logic [1:0] o);
    case (w)
      W8:      return 4'b0001 << o;
      W16:     return 4'b0011 << o;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_shift_wr(input logic [31:0] d, input logic [1:0] o);
    return d << {o, 3'b000};
  endfunction

  function automatic logic [31:0] lane_extract_rd(input logic [31:0] d, input logic [1:0] o,
                                                  input width_e w);
    logic [31:0] s;
    s = d >> {o, 3'b000};
    case (w)
      W8:      return {24'h0, s[7:0]};
      W16:     return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester channels plus memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 26,
  parameter int MEM_AW = 17
);
  logic [N_CH-1:0]        ch_rd;
  logic [N_CH-1:0]        ch_wr;
  logic [N_CH*2-1:0]      ch_width;
  logic [N_CH*ADDR_W-1:0] ch_addr;
  logic [N_CH*32-1:0]     ch_wr_data;
  logic [N_CH-1:0]        ch_ack;
  logic [N_CH-1:0]        ch_rd_valid;
  logic [31:0]            ch_rd_data;
  logic [1:0]             mem_cmd;
  logic [MEM_AW-1:0]      mem_addr;
  logic [3:0]             mem_be;
  logic [31:0]            mem_wr_data;
  logic [31:0]            mem_rd_data;

  modport slave (
    input  ch_rd, ch_wr, ch_width, ch_addr, ch_wr_data, mem_rd_data,
    output ch_ack, ch_rd_valid, ch_rd_data, mem_cmd, mem_addr, mem_be, mem_wr_data
  );

  modport master (
    output ch_rd, ch_wr, ch_width, ch_addr, ch_wr_data, mem_rd_data,
    input  ch_ack, ch_rd_valid, ch_rd_data, mem_cmd, mem_addr, mem_be, mem_wr_data
  );
endinterface

// File: rtl/mem_port_arbiter_rd_pipe.sv
// rtl/mem_port_arbiter_rd_pipe.sv - read tag delay line and return lane extraction
module mem_arb_rd_pipe
  import mem_arb_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int MEM_RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  rd_tag_t         tag_in,
  input  logic [31:0]     mem_rd_data,
  output logic [N_CH-1:0] rd_valid,
  output logic [31:0]     rd_data
);
  // Stage MEM_RD_LAT lines up with the cycle the memory presents the data.
  rd_tag_t stage [MEM_RD_LAT+1];
  rd_tag_t ret;

  assign ret = stage[MEM_RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= MEM_RD_LAT; i++) stage[i] <= '0;
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i <= MEM_RD_LAT; i++) stage[i] <= stage[i-1];
      rd_valid <= '0;
      rd_data  <= '0;
      if (ret.valid) begin
        for (int c = 0; c < N_CH; c++) begin
          if (ret.ch == 3'(c)) rd_valid[c] <= 1'b1;
        end
        rd_data <= lane_extract_rd(mem_rd_data, ret.off, ret.width);
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-channel requester arbiter onto one 32-bit memory port
// Defining MEM_ARB_RR_EN selects round-robin grant; otherwise the lowest channel index wins.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int ADDR_W     = 26,
  parameter int MEM_AW     = 17,
  parameter int MEM_RD_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  logic [N_CH-1:0]   ack_q;
  logic [N_CH-1:0]   elig;
  logic [N_CH-1:0]   gnt_oh;
  logic              gnt_any;
  logic [2:0]        gnt_ch;
  logic              sel_wr;
  logic [MEM_AW+1:0] sel_addr;
  logic [31:0]       sel_wd;
  logic [1:0]        sel_wbits;
  width_e            sel_w;
  logic [1:0]        sel_off;
  rd_tag_t           tag_in;
  mem_cmd_e          cmd_q;
  logic [MEM_AW-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wd_q;
  logic [N_CH-1:0]   rd_valid;
  logic [31:0]       rd_data;

  // A channel acked last cycle still shows its old request level; skip it.
  assign elig = (bus.ch_rd | bus.ch_wr) & ~ack_q;

`ifdef MEM_ARB_RR_EN
  logic [2:0] rr_ptr;
  logic [3:0] idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    idx     = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(N_CH)) idx = idx - 4'(N_CH);
      for (int j = 0; j < N_CH; j++) begin
        if (!gnt_any && idx == 4'(j) && elig[j]) begin
          gnt_any = 1'b1;
          gnt_ch  = 3'(j);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_ch == 3'(N_CH - 1)) ? 3'd0 : gnt_ch + 3'd1;
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_ch  = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (elig[k]) begin
        gnt_any = 1'b1;
        gnt_ch  = 3'(k);
      end
    end
  end
`endif

  always_comb begin
    gnt_oh    = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wd    = '0;
    sel_wbits = 2'b00;
    for (int k = 0; k < N_CH; k++) begin
      if (gnt_any && gnt_ch == 3'(k)) begin
        gnt_oh[k] = 1'b1;
        sel_wr    = bus.ch_wr[k];
        sel_addr  = bus.ch_addr[k*ADDR_W +: MEM_AW+2];
        sel_wd    = bus.ch_wr_data[k*32 +: 32];
        sel_wbits = bus.ch_width[k*2 +: 2];
      end
    end
  end

  assign sel_w   = norm_width(sel_wbits);
  assign sel_off = lane_off(sel_w, sel_addr[1:0]);
  // Writes take precedence; a pending read on the same channel re-arbitrates later.
  assign tag_in  = '{valid: gnt_any && !sel_wr, ch: gnt_ch, off: sel_off, width: sel_w};

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q  <= '0;
      cmd_q  <= CMD_IDLE;
      addr_q <= '0;
      be_q   <= '0;
      wd_q   <= '0;
    end else begin
      ack_q  <= gnt_oh;
      cmd_q  <= !gnt_any ? CMD_IDLE : (sel_wr ? CMD_WRITE : CMD_READ);
      addr_q <= gnt_any ? sel_addr[MEM_AW+1:2] : '0;
      be_q   <= (gnt_any && sel_wr) ? lane_be(sel_w, sel_off) : 4'b0000;
      wd_q   <= (gnt_any && sel_wr) ? lane_shift_wr(sel_wd, sel_off) : 32'h0;
    end
  end

  mem_arb_rd_pipe #(
    .N_CH       (N_CH),
    .MEM_RD_LAT (MEM_RD_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .tag_in      (tag_in),
    .mem_rd_data (bus.mem_rd_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data)
  );

  assign bus.ch_ack      = ack_q;
  assign bus.mem_cmd     = cmd_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_be      = be_q;
  assign bus.mem_wr_data = wd_q;
  assign bus.ch_rd_valid = rd_valid;
  assign bus.ch_rd_data  = rd_data;
endmodule
